// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - single-clock VGA scan-out with framebuffer fetch, pixel divider and replication
module vga_scanout #(
    parameter int H_SYNC      = 120,
    parameter int H_BACK      = 64,
    parameter int H_ACTIVE    = 800,
    parameter int H_FRONT     = 56,
    parameter int V_SYNC      = 6,
    parameter int V_BACK      = 23,
    parameter int V_ACTIVE    = 600,
    parameter int V_FRONT     = 37,
    parameter int HSYNC_POL   = 1,
    parameter int VSYNC_POL   = 1,
    parameter int PIX_DIV     = 1,
    parameter int SCALE_SHIFT = 1,
    parameter int FMT         = 0,
    parameter int PIX_W       = 12,
    parameter int CNT_WIDTH   = 11,
    parameter int ADDR_WIDTH  = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] vmem_raddr,
    input  logic [PIX_W-1:0]      vmem_rdata,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t H_LAST      = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST      = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_SYNC_END  = cnt_t'(H_SYNC);
    localparam cnt_t V_SYNC_END  = cnt_t'(V_SYNC);
    localparam cnt_t H_VIS_START = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t H_VIS_END   = cnt_t'(H_SYNC + H_BACK + H_ACTIVE);
    localparam cnt_t V_VIS_START = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t V_VIS_END   = cnt_t'(V_SYNC + V_BACK + V_ACTIVE);
    localparam cnt_t SCALE_MASK  = cnt_t'((1 << SCALE_SHIFT) - 1);

    localparam logic [ADDR_WIDTH-1:0] FB_W     = ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic                  HS_ON    = 1'(HSYNC_POL);
    localparam logic                  VS_ON    = 1'(VSYNC_POL);

    logic [DIV_W-1:0]      div_cnt;
    cnt_t                  h_cnt;
    cnt_t                  v_cnt;
    logic [ADDR_WIDTH-1:0] line_base;
    logic                  en_latch;

    logic                  tick;
    logic                  h_wrap;
    logic                  frame_wrap;
    logic                  h_vis;
    logic                  v_vis;
    logic                  row_done;
    logic [ADDR_WIDTH-1:0] pix_addr;

    logic de_d1, hs_d1, vs_d1, fs_d1;
    logic de_d2, hs_d2, vs_d2, fs_d2;
    logic [3:0] pix_r, pix_g, pix_b;

    assign tick       = (div_cnt == DIV_LAST);
    assign h_wrap     = tick && (h_cnt == H_LAST);
    assign frame_wrap = h_wrap && (v_cnt == V_LAST);
    assign h_vis      = (h_cnt >= H_VIS_START) && (h_cnt < H_VIS_END);
    assign v_vis      = (v_cnt >= V_VIS_START) && (v_cnt < V_VIS_END);
    // The next line begins a new framebuffer row once every 2^SCALE_SHIFT visible lines.
    assign row_done   = (((v_cnt - V_VIS_START) + cnt_t'(1)) & SCALE_MASK) == '0;
    assign pix_addr   = line_base + ADDR_WIDTH'((h_cnt - H_VIS_START) >> SCALE_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            line_base <= '0;
            en_latch  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
            end
            if (h_wrap) begin
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                if (v_cnt == V_LAST) begin
                    line_base <= '0;
                end else if (v_vis && row_done) begin
                    line_base <= line_base + FB_W;
                end
            end
            if (frame_wrap) begin
                en_latch <= en;
            end
        end
    end

    generate
        if (FMT == 0) begin : g_rgb444
            assign pix_r = vmem_rdata[11:8];
            assign pix_g = vmem_rdata[7:4];
            assign pix_b = vmem_rdata[3:0];
        end else begin : g_rgb332
            assign pix_r = {vmem_rdata[7:5], vmem_rdata[7]};
            assign pix_g = {vmem_rdata[4:2], vmem_rdata[4]};
            assign pix_b = {vmem_rdata[1:0], vmem_rdata[1:0]};
        end
    endgenerate

    // Stage 1 registers the address, stage 2 waits on memory, stage 3 drives the pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            vmem_raddr  <= '0;
            de_d1       <= 1'b0;
            hs_d1       <= 1'b0;
            vs_d1       <= 1'b0;
            fs_d1       <= 1'b0;
            de_d2       <= 1'b0;
            hs_d2       <= 1'b0;
            vs_d2       <= 1'b0;
            fs_d2       <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            frame_start <= 1'b0;
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
        end else begin
            if (h_vis && v_vis) begin
                vmem_raddr <= pix_addr;
            end
            de_d1 <= h_vis && v_vis && en_latch;
            hs_d1 <= (h_cnt < H_SYNC_END);
            vs_d1 <= (v_cnt < V_SYNC_END);
            fs_d1 <= (div_cnt == '0) && (h_cnt == '0) && (v_cnt == '0);

            de_d2 <= de_d1;
            hs_d2 <= hs_d1;
            vs_d2 <= vs_d1;
            fs_d2 <= fs_d1;

            de          <= de_d2;
            hsync       <= hs_d2 ? HS_ON : ~HS_ON;
            vsync       <= vs_d2 ? VS_ON : ~VS_ON;
            frame_start <= fs_d2;
            vga_r       <= de_d2 ? pix_r : 4'h0;
            vga_g       <= de_d2 ? pix_g : 4'h0;
            vga_b       <= de_d2 ? pix_b : 4'h0;
        end
    end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Single-clock VGA scan-out engine. It generates parameterised horizontal/vertical timing and fetches pixels from a framebuffer with 1-cycle read latency. It supports an integer pixel-clock divider, power-of-two pixel replication and two pixel formats, and drives 4-bit-per-channel RGB with aligned sync/DE. It sits between the video memory read port and the board VGA pins, and replaces the dual-clock controller/display pair on designs clocked from a single pixel-multiple clock.

Parameters:
H_SYNC, 120, hsync width in pixels
H_BACK, 64, horizontal back porch in pixels
H_ACTIVE, 800, visible pixels per line
H_FRONT, 56, horizontal front porch in pixels
V_SYNC, 6, vsync width in lines
V_BACK, 23, vertical back porch in lines
V_ACTIVE, 600, visible lines
V_FRONT, 37, vertical front porch in lines
HSYNC_POL, 1, asserted level of hsync
VSYNC_POL, 1, asserted level of vsync
PIX_DIV, 1, clk cycles per pixel (>=1)
SCALE_SHIFT, 1, each framebuffer pixel is shown as a 2^SCALE_SHIFT x 2^SCALE_SHIFT block
FMT, 0, pixel format: 0 = RGB444 in rdata[11:0]; 1 = RGB332 in rdata[7:0]
PIX_W, 12, vmem_rdata width
CNT_WIDTH, 11, h/v counter width
ADDR_WIDTH, 17, framebuffer word address width

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-high reset
en  in  1  display enable, sampled at frame start
vmem_raddr  out  ADDR_WIDTH  framebuffer read address, one pixel per word
vmem_rdata  in  PIX_W  read data, valid exactly 1 clk after vmem_raddr
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable (visible pixel)
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
frame_start  out  1  1-clk pulse at the first pixel of each frame

Behaviour:
- Reset: clk sampled with reset=1 clears all state. hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, rgb=0, vmem_raddr=0, frame_start=0. Counters, divider, pipeline and enable latch are all cleared. Reset mid-frame restarts the frame at (0,0) in the following cycle.
- Pixel tick: divider counts 0..PIX_DIV-1 and ticks when it reaches PIX_DIV-1. PIX_DIV=1 ticks every clk.
- h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of the four H params) on each tick, then wraps. v_cnt advances when h_cnt wraps and counts 0..V_TOTAL-1.
- Region order per line/frame: sync, back porch, active, front porch.
  - Sync asserted while h_cnt<H_SYNC (v_cnt<V_SYNC).
  - Visible when H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, and likewise vertically.
- Address rules:
  - x = (h_cnt-H_SYNC-H_BACK)>>SCALE_SHIFT; y likewise vertically.
  - FB_W = H_ACTIVE>>SCALE_SHIFT.
  - vmem_raddr = y*FB_W + x, modulo 2^ADDR_WIDTH. No multiplier: use an incremental line-base register.
  - Outside the visible region, vmem_raddr holds its last value.
- Pipeline, fixed at 3 clk from counter state to pins:
  - T: counter state.
  - T+1: registered vmem_raddr.
  - T+2: rdata returns.
  - T+3: rgb/de/hsync/vsync/frame_start registered.
  - Syncs and de pass through a matched 3-stage delay, so all outputs align.
- Pixel conversion:
  - FMT 0: r=rdata[11:8], g=[7:4], b=[3:0].
  - FMT 1: r={rdata[7:5],rdata[7]}, g={rdata[4:2],rdata[4]}, b={rdata[1:0],rdata[1:0]}.
- Blanking: whenever de=0, rgb=0.
- Enable: en is latched when counters wrap to (0,0). If the latch is 0, rgb=0 and de=0 for the whole frame, while syncs and frame_start continue. Toggling en mid-frame has no effect until the next frame.
- frame_start: asserted for exactly 1 clk, 3 clk after the counter state reaches (0,0) on a tick. It also fires after reset.
- PIX_DIV>1: each output value is held for PIX_DIV clks. vmem_raddr changes at most once per tick.

Test Plan:
- Reset: hold reset for 5 clk, release -> all outputs at reset values; first frame_start pulse 3 clk after release; a further reset asserted mid-line -> frame_start 3 clk after reset deasserts.
- Default timing, PIX_DIV=1 -> hsync high for 120 of every 1040 clk; vsync high for 6 of every 666 lines; frame_start period 692640 clk; de high for 800 clk per line on 600 lines.
- Address sequence, SCALE_SHIFT=1 -> first visible line reads 0,0,1,1,...,399,399; second line repeats; third line starts at 400; last address 119999. rgb equals the model's rdata converted and delayed 3 clk.
- PIX_DIV=2 -> all periods double (frame 1385280 clk); each rgb value is stable for 2 clk; vmem_raddr changes at most every 2 clk.
- FMT=1, rdata=8'hE3 -> r=4'hF, g=4'h0, b=4'hF; rdata=8'h49 -> r=4'h4, g=4'h4, b=4'h5.
- en dropped at mid-frame line 300 -> current frame still displays; next frame has de=0 and rgb=0 throughout; syncs unchanged; re-assert en -> display resumes at the following frame.
